fsm_seq_ctrl: RTL and testbench
===============================

FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the maximum pattern length in bits (2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset that is synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-006 The block SHALL have port cmd_pattern, input, WIDTH bits: stimulus bits, sent MSB-first from bit cmd_len-1.
REQ-007 The block SHALL have port cmd_len, input, $clog2(WIDTH+1) bits: number of bits to send (0..WIDTH).
REQ-008 The block SHALL have port abort, input, 1 bit: early termination request.
REQ-009 The block SHALL have port fsm_x, output, 1 bit: serial x driven into the sequenced FSM.
REQ-010 The block SHALL have port fsm_x_valid, output, 1 bit: high while fsm_x carries a pattern bit.
REQ-011 The block SHALL have port fsm_y, input, 1 bit: Mealy y output of the FSM for the current fsm_x.
REQ-012 The block SHALL have port fsm_reset, output, 1 bit: FSM re-initialise pulse (see Configuration).
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port aborted, output, 1 bit: last run ended by abort.
REQ-015 The block SHALL have port resp, output, WIDTH bits: captured y bits, newest in bit 0.
REQ-016 The block SHALL have port ones_cnt, output, $clog2(WIDTH+1) bits: count of y=1 samples in the last run.

Function
REQ-017 The block SHALL implement states IDLE, INIT, SHIFT and DONE.
REQ-018 A command SHALL be accepted on an edge with cmd_valid && cmd_ready; pattern and len are latched, resp, ones_cnt and aborted are cleared, and the next state is INIT (macro on) or SHIFT (macro off).
REQ-019 A command with cmd_len = 0 SHALL go directly to DONE, with resp = 0 and ones_cnt = 0.
REQ-020 In SHIFT, fsm_x SHALL be pattern bit (len-1-i) on the i-th SHIFT cycle, and fsm_x_valid SHALL be 1.
REQ-021 Each SHIFT cycle SHALL sample fsm_y at the closing edge: resp <= {resp[WIDTH-2:0], fsm_y}, and ones_cnt increments if fsm_y = 1.
REQ-022 After exactly len SHIFT cycles the block SHALL enter DONE; done = 1 for that single cycle, then the state returns to IDLE.
REQ-023 resp, ones_cnt and aborted SHALL hold their values from DONE until the next command is accepted.
REQ-024 Outside SHIFT, fsm_x and fsm_x_valid SHALL be 0.
REQ-025 If abort = 1 in a SHIFT cycle, that cycle's y SHALL still be captured, the next state SHALL be DONE, and aborted SHALL be set to 1; this includes abort on the final bit.
REQ-026 abort SHALL be ignored in IDLE, INIT and DONE.
REQ-027 cmd_valid SHALL be ignored in every state other than IDLE; no queuing.
REQ-028 A cmd_len greater than WIDTH SHALL be saturated to WIDTH.

Reset
REQ-029 When reset_n = 0 at a clock edge, the block SHALL enter IDLE and force resp = 0, ones_cnt = 0, aborted = 0, done = 0, fsm_x = 0, fsm_x_valid = 0 and fsm_reset = 0, in any state, including mid-SHIFT.
REQ-030 After reset, cmd_ready SHALL be 1 in the first cycle with reset_n = 1.

Configuration
REQ-031 With FSM_SEQ_CTRL_FSM_RESET_EN defined, the INIT state SHALL exist and last one cycle with fsm_reset = 1, giving done in cycle len+2 after acceptance.
REQ-032 Without FSM_SEQ_CTRL_FSM_RESET_EN, INIT SHALL be omitted, fsm_reset SHALL be tied 0, and done SHALL occur in cycle len+1 after acceptance.

Structure
REQ-033 Package fsm_seq_pkg SHALL hold the state enum type (IDLE, INIT, SHIFT, DONE) and the localparam function for the counter width.
REQ-034 One sub-module, seq_resp_capture, SHALL hold the resp shift register and ones_cnt counter, with clear and capture enables driven by the controller.

Verification
REQ-035 With fsm_y looped to fsm_x, pattern 0x00A5 and len 8: resp = 0x00A5 and ones_cnt = 4; done is seen in cycle 10 with the macro and cycle 9 without.
REQ-036 With fsm_y tied 1, len 16: resp = 0xFFFF, ones_cnt = 16 (counter does not wrap), aborted = 0.
REQ-037 With len 0: done in cycle 1, resp = 0, ones_cnt = 0, and fsm_x_valid never high.
REQ-038 With loopback, pattern 0x000F, len 8, abort in the 3rd SHIFT cycle: resp = 0x0000, ones_cnt = 0, aborted = 1, done in the next cycle.
REQ-039 With reset_n low in the 4th SHIFT cycle: next cycle the state is IDLE, all outputs are 0 and cmd_ready = 1; a new command then runs normally.
REQ-040 With cmd_valid held high through a run: exactly one acceptance per IDLE visit, and the second command starts the cycle after done.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared state encoding and counter-width helper for the FSM sequencer
// Contents:
//   state_e - controller states IDLE, INIT, SHIFT, DONE
//   cnt_w   - bits needed to hold a count from 0 to w inclusive
package fsm_seq_pkg;
  typedef enum logic [1:0] {IDLE, INIT, SHIFT, DONE} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_resp_capture.sv
// seq_resp_capture: collects the sequenced FSM's y bits and counts the ones
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   clr           - zero resp and ones_cnt (command acceptance)
//   cap           - shift y into resp and count it (one SHIFT cycle)
//   y             - sampled FSM output bit
//   resp          - captured bits, newest in bit 0
//   ones_cnt      - number of captured ones
module seq_resp_capture
  import fsm_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cap,
  input  logic             y,
  output logic [WIDTH-1:0] resp,
  output logic [CW-1:0]    ones_cnt
);
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [CW-1:0]    ones_q, ones_d;
  always_comb begin
    resp_d = clr ? '0 : cap ? {resp_q[WIDTH-2:0], y} : resp_q;
    ones_d = clr ? '0 : ones_q + CW'(cap & y);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_q <= '0;
      ones_q <= '0;
    end else begin
      resp_q <= resp_d;
      ones_q <= ones_d;
    end
  end
  assign resp     = resp_q;
  assign ones_cnt = ones_q;
endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: drives a serial bit pattern into an external Mealy FSM and captures its y response
// Ports:
//   clk, reset_n              - clock, synchronous active-low reset
//   cmd_valid/cmd_ready       - command handshake (ready only in IDLE)
//   cmd_pattern, cmd_len      - bits to send MSB-first from bit cmd_len-1; len saturates at WIDTH
//   abort                     - end the run after the current SHIFT cycle
//   fsm_x, fsm_x_valid        - serial stimulus to the sequenced FSM
//   fsm_y                     - FSM response for the current fsm_x
//   fsm_reset                 - one-cycle FSM re-initialise pulse before shifting
//   done, aborted             - completion pulse, last run ended by abort
//   resp, ones_cnt            - captured y bits (newest in bit 0) and their count of ones
// Build option: define FSM_SEQ_CTRL_FSM_RESET_EN to insert the INIT state that pulses fsm_reset;
// otherwise INIT is skipped and fsm_reset stays 0.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_pattern,
  input  logic [CW-1:0]    cmd_len,
  input  logic             abort,
  output logic             fsm_x,
  output logic             fsm_x_valid,
  input  logic             fsm_y,
  output logic             fsm_reset,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] resp,
  output logic [CW-1:0]    ones_cnt
);
  localparam logic [CW-1:0] WMAX = CW'(WIDTH);
`ifdef FSM_SEQ_CTRL_FSM_RESET_EN
  localparam state_e FIRST = INIT;
  logic frst_q, frst_d;
`else
  localparam state_e FIRST = SHIFT;
`endif
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CW-1:0]    cnt_q, cnt_d, len_sat;
  logic             aborted_q, aborted_d;
  logic             ready_q, ready_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             done_q, done_d;
  logic             clr, cap;
  // pat_q is left-aligned so the next bit to send is always its MSB;
  // cnt_q is the number of bits still to send including the current one
  always_comb begin
    len_sat   = cmd_len > WMAX ? WMAX : cmd_len;
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    clr       = 1'b0;
    cap       = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        clr       = 1'b1;
        aborted_d = 1'b0;
        cnt_d     = len_sat;
        pat_d     = cmd_pattern << (WMAX - len_sat);
        state_d   = len_sat == '0 ? DONE : FIRST;
      end
      INIT: state_d = SHIFT;
      SHIFT: begin
        cap       = 1'b1;
        pat_d     = pat_q << 1;
        cnt_d     = cnt_q - 1'b1;
        aborted_d = aborted_q | abort;
        state_d   = (abort || cnt_q == CW'(1)) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    xv_d    = state_d == SHIFT;
    x_d     = xv_d & pat_d[WIDTH-1];
    done_d  = state_d == DONE;
`ifdef FSM_SEQ_CTRL_FSM_RESET_EN
    frst_d  = state_d == INIT;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
      x_q       <= 1'b0;
      xv_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef FSM_SEQ_CTRL_FSM_RESET_EN
      frst_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
      x_q       <= x_d;
      xv_q      <= xv_d;
      done_q    <= done_d;
`ifdef FSM_SEQ_CTRL_FSM_RESET_EN
      frst_q    <= frst_d;
`endif
    end
  end
  seq_resp_capture #(.WIDTH(WIDTH)) u_cap (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .cap      (cap),
    .y        (fsm_y),
    .resp     (resp),
    .ones_cnt (ones_cnt)
  );
  assign cmd_ready   = ready_q;
  assign fsm_x       = x_q;
  assign fsm_x_valid = xv_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
`ifdef FSM_SEQ_CTRL_FSM_RESET_EN
  assign fsm_reset   = frst_q;
`else
  assign fsm_reset   = 1'b0;
`endif
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: scoreboard bench for fsm_seq_ctrl using loopback / tied-high FSM models
module tb_fsm_seq_ctrl;
  localparam int W  = 16;
  localparam int CW = 5;
`ifdef FSM_SEQ_CTRL_FSM_RESET_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  typedef struct {
    logic [W-1:0] resp;
    int           ones;
    logic         ab;
    int           lat;
    int           nx;
    int           nf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic          y_one = 1'b0;
  logic [W-1:0]  cmd_pattern = '0;
  logic [CW-1:0] cmd_len = '0;
  logic          cmd_ready, fsm_x, fsm_x_valid, fsm_y, fsm_reset, done, aborted;
  logic [W-1:0]  resp;
  logic [CW-1:0] ones_cnt;

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, acc = 0, nxv = 0, nfr = 0, n_acc = 0, n_iss = 0;

  fsm_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_pattern (cmd_pattern),
    .cmd_len     (cmd_len),
    .abort       (abort),
    .fsm_x       (fsm_x),
    .fsm_x_valid (fsm_x_valid),
    .fsm_y       (fsm_y),
    .fsm_reset   (fsm_reset),
    .done        (done),
    .aborted     (aborted),
    .resp        (resp),
    .ones_cnt    (ones_cnt)
  );

  // y_one=0: FSM is a wire (y = x); y_one=1: FSM output stuck at 1
  assign fsm_y = y_one | fsm_x;

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input int o, input logic a, input int lat,
                              input int nx, input int nf);
    exp_t e;
    e.resp = r; e.ones = o; e.ab = a; e.lat = lat; e.nx = nx; e.nf = nf;
    return e;
  endfunction

  // monitor: cycle counter, acceptance tracking and scoreboard check on every done pulse
  always @(negedge clk) begin
    #1;
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pending run", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp", resp, e.resp);
        chk("ones_cnt", ones_cnt, e.ones);
        chk("aborted", aborted, e.ab);
        chk("done_latency", cyc - acc, e.lat);
        chk("x_valid_cycles", nxv, e.nx);
        chk("fsm_reset_cycles", nfr, e.nf);
      end
    end
    if (fsm_x_valid) nxv++;
    if (fsm_reset) nfr++;
    if (reset_n && cmd_valid && cmd_ready) begin
      acc = cyc;
      nxv = 0;
      nfr = 0;
      n_acc++;
    end
  end

  task automatic wait_done(input string n);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done, expected done within 200 cycles", n);
    end
  endtask

  task automatic send(input logic [W-1:0] p, input logic [CW-1:0] l, input logic y1, input int ab_at,
                      input logic [W-1:0] er, input int eo);
    int le, k;
    le = (l > W) ? W : int'(l);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got cmd_ready=0, expected 1 within 50 cycles");
    end
    y_one = y1;
    abort = 1'b0;
    cmd_pattern = p;
    cmd_len = l;
    cmd_valid = 1'b1;
    sb.push_back(mk(er, eo, ab_at > 0,
                    le == 0 ? 1 : (ab_at > 0 ? OFF + ab_at + 1 : le + 1 + OFF),
                    ab_at > 0 ? ab_at : le, le > 0 ? OFF : 0));
    n_iss++;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ab_at > 0) begin
      repeat (OFF + ab_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done("run");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_resp", resp, 0);
    chk("rst_ones", ones_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_xv", fsm_x_valid, 0);
    reset_n = 1'b1;
    send(16'h00A5, 8, 1'b0, 0, 16'h00A5, 4);
    send(16'h1234, 16, 1'b1, 0, 16'hFFFF, 16);
    send(16'hFFFF, 0, 1'b0, 0, 16'h0000, 0);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_ignored_done_idle", aborted, 0);
    chk("idle_ready", cmd_ready, 1);
    send(16'h000F, 8, 1'b0, 3, 16'h0000, 0);
    send(16'hBEEF, 5'd31, 1'b0, 0, 16'hBEEF, 13);
    send(16'h0003, 2, 1'b0, 2, 16'h0003, 2);
    // reset in the 4th SHIFT cycle of a run, after an aborted run left aborted=1
    @(negedge clk);
    chk("pre_mid_ready", cmd_ready, 1);
    y_one = 1'b0;
    cmd_pattern = 16'h00FF;
    cmd_len = 8;
    cmd_valid = 1'b1;
    n_iss++;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (OFF + 3) @(negedge clk);
    chk("mid_shift_xv", fsm_x_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_resp", resp, 0);
    chk("mid_rst_ones", ones_cnt, 0);
    chk("mid_rst_aborted", aborted, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_x", fsm_x, 0);
    chk("mid_rst_xv", fsm_x_valid, 0);
    chk("mid_rst_fsm_reset", fsm_reset, 0);
    send(16'h0155, 9, 1'b0, 0, 16'h0155, 5);
    // cmd_valid held high across two runs
    @(negedge clk);
    chk("held_pre_ready", cmd_ready, 1);
    y_one = 1'b0;
    cmd_pattern = 16'h000C;
    cmd_len = 4;
    cmd_valid = 1'b1;
    sb.push_back(mk(16'h000C, 2, 1'b0, 5 + OFF, 4, OFF));
    n_iss++;
    @(negedge clk);
    cmd_pattern = 16'h0005;
    cmd_len = 3;
    sb.push_back(mk(16'h0005, 2, 1'b0, 4 + OFF, 3, OFF));
    n_iss++;
    wait_done("held1");
    chk("held_done_ready", cmd_ready, 0);
    @(negedge clk);
    chk("held_idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_accepted", cmd_ready, 0);
    wait_done("held2");
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("accept_count", n_acc, n_iss);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule
